// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: resolves stage stall/flush requests into per-register Pass/Hold/Bubb codes
`ifndef Pass
`define Pass 2'b00
`endif
`ifndef Hold
`define Hold 2'b01
`endif
`ifndef Bubb
`define Bubb 2'b10
`endif

module ctrl_pipe_hazard #(
    parameter int NSTAGE = 4,
    parameter int AW     = 32,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSTAGE-1:0]       stall_req,
    input  logic [NSTAGE-1:0]       flush_req,
    input  logic [NSTAGE*AW-1:0]    flush_addr,
    output logic [2*(NSTAGE+1)-1:0] stall_ctrl,
    output logic                    redirect_valid,
    output logic [AW-1:0]           redirect_addr,
    output logic                    flush_pending,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_count
);
    localparam int IW = NSTAGE > 1 ? $clog2(NSTAGE) : 1;

    logic             pend_v_q, pend_v_d;
    logic [IW-1:0]    pend_k_q, pend_k_d;
    logic [AW-1:0]    pend_a_q, pend_a_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             stall_any, live_any, use_live, cand_v, blocked, apply, any_hold;
    logic [IW-1:0]    stall_j, live_k, cand_k;
    logic [AW-1:0]    cand_a;

    // Oldest (highest-index) stalling stage and oldest live redirect
    always_comb begin
        stall_any = 1'b0;
        stall_j   = '0;
        live_any  = 1'b0;
        live_k    = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            if (stall_req[s]) begin
                stall_any = 1'b1;
                stall_j   = IW'(s);
            end
            if (flush_req[s]) begin
                live_any = 1'b1;
                live_k   = IW'(s);
            end
        end
    end

    // Pick the flush candidate; a live request younger than the pending one is dropped
    always_comb begin
        use_live = live_any && (!pend_v_q || live_k >= pend_k_q);
        cand_v   = live_any || pend_v_q;
        cand_k   = use_live ? live_k : pend_k_q;
        cand_a   = use_live ? flush_addr[int'(live_k)*AW +: AW] : pend_a_q;
        blocked  = stall_any && stall_j >= cand_k;
        apply    = rst_n && cand_v && !blocked;
    end

    // Per-register control codes; an applied flush overrides any younger stall
    always_comb begin
        stall_ctrl = '0;
        for (int i = 0; i <= NSTAGE; i++) begin
            if (!rst_n)
                stall_ctrl[2*i +: 2] = `Bubb;
            else if (apply)
                stall_ctrl[2*i +: 2] = (i >= 1 && i <= int'(cand_k)) ? `Bubb : `Pass;
            else if (stall_any && i <= int'(stall_j))
                stall_ctrl[2*i +: 2] = `Hold;
            else if (stall_any && i == int'(stall_j) + 1)
                stall_ctrl[2*i +: 2] = `Bubb;
            else
                stall_ctrl[2*i +: 2] = `Pass;
        end
        any_hold       = rst_n && !apply && stall_any;
        redirect_valid = apply;
        redirect_addr  = apply ? cand_a : '0;
    end

    // Next pending flush and saturating event counts
    always_comb begin
        pend_v_d    = cand_v && blocked;
        pend_k_d    = (cand_v && blocked) ? cand_k : pend_k_q;
        pend_a_d    = (cand_v && blocked) ? cand_a : pend_a_q;
        stall_cnt_d = (any_hold && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (apply && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    // State registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_v_q    <= 1'b0;
            pend_k_q    <= '0;
            pend_a_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_k_q    <= pend_k_d;
            pend_a_q    <= pend_a_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_pending = pend_v_q;
    assign stall_cycles  = stall_cnt_q;
    assign flush_count   = flush_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard: directed vectors with a scoreboard queue checked by a negedge monitor
`ifndef Pass
`define Pass 2'b00
`endif
`ifndef Hold
`define Hold 2'b01
`endif
`ifndef Bubb
`define Bubb 2'b10
`endif

module tb_ctrl_pipe_hazard;
    localparam logic [1:0] P = `Pass;
    localparam logic [1:0] H = `Hold;
    localparam logic [1:0] B = `Bubb;

    typedef struct packed {
        logic [9:0]  c;
        logic        rv;
        logic [31:0] ra;
        logic        fp;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   stall_req = '0;
    logic [3:0]   flush_req = '0;
    logic [127:0] flush_addr = '0;
    logic [9:0]   stall_ctrl;
    logic         redirect_valid;
    logic [31:0]  redirect_addr;
    logic         flush_pending;
    logic [3:0]   stall_cycles;
    logic [3:0]   flush_count;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    ctrl_pipe_hazard #(.NSTAGE(4), .AW(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
        .flush_addr(flush_addr), .stall_ctrl(stall_ctrl), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .flush_pending(flush_pending),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] cc(input logic [1:0] f4, f3, f2, f1, f0);
        return {f4, f3, f2, f1, f0};
    endfunction

    task automatic vec(input logic r, input logic [3:0] st, input logic [3:0] fl,
                       input int k, input logic [31:0] a, input logic [9:0] ec,
                       input logic erv, input logic [31:0] era, input logic efp,
                       input logic [3:0] esc, input logic [3:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = r;
        stall_req  = st;
        flush_req  = fl;
        flush_addr = {4{32'hEEEE_EEEE}};
        flush_addr[k*32 +: 32] = a;
        e = '{c: ec, rv: erv, ra: era, fp: efp, sc: esc, fc: efc};
        q.push_back(e);
    endtask

    // Monitor: every cycle carries an output; compare it with the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (stall_ctrl !== e.c) begin
                n_bad++;
                $display("FAIL vec%0d stall_ctrl got %b want %b", n_vec, stall_ctrl, e.c);
            end
            if (redirect_valid !== e.rv) begin
                n_bad++;
                $display("FAIL vec%0d redirect_valid got %b want %b", n_vec, redirect_valid, e.rv);
            end
            if (redirect_addr !== e.ra) begin
                n_bad++;
                $display("FAIL vec%0d redirect_addr got %h want %h", n_vec, redirect_addr, e.ra);
            end
            if (flush_pending !== e.fp) begin
                n_bad++;
                $display("FAIL vec%0d flush_pending got %b want %b", n_vec, flush_pending, e.fp);
            end
            if (stall_cycles !== e.sc) begin
                n_bad++;
                $display("FAIL vec%0d stall_cycles got %0d want %0d", n_vec, stall_cycles, e.sc);
            end
            if (flush_count !== e.fc) begin
                n_bad++;
                $display("FAIL vec%0d flush_count got %0d want %0d", n_vec, flush_count, e.fc);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // reset overrides requests
        vec(0, 4'b0001, 4'b1000, 3, 32'h0000_9000, cc(B,B,B,B,B), 0, 0, 0, 0, 0);
        // idle
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 0, 0);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 0, 0);
        // stall at stage 2
        vec(1, 4'b0100, 4'b0000, 0, 0, cc(P,B,H,H,H), 0, 0, 0, 0, 0);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 1, 0);
        // direct flush at stage 2
        vec(1, 4'b0000, 4'b0100, 2, 32'h0000_1000, cc(P,P,B,B,P), 1, 32'h0000_1000, 0, 1, 0);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 1, 1);
        // deferred flush behind stall at stage 3, request drops after deferral
        vec(1, 4'b1000, 4'b0100, 2, 32'h0000_2000, cc(B,H,H,H,H), 0, 0, 0, 1, 1);
        vec(1, 4'b1000, 4'b0000, 0, 0, cc(B,H,H,H,H), 0, 0, 1, 2, 1);
        vec(1, 4'b1000, 4'b0000, 0, 0, cc(B,H,H,H,H), 0, 0, 1, 3, 1);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,B,B,P), 1, 32'h0000_2000, 1, 4, 1);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 4, 2);
        // pending k=1 loses to live k=3
        vec(1, 4'b0010, 4'b0010, 1, 32'h0000_1111, cc(P,P,B,H,H), 0, 0, 0, 4, 2);
        vec(1, 4'b0000, 4'b1000, 3, 32'h0000_3000, cc(P,B,B,B,P), 1, 32'h0000_3000, 1, 5, 2);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 5, 3);
        // live k=0 ignored against pending k=2
        vec(1, 4'b0100, 4'b0100, 2, 32'h0000_4444, cc(P,B,H,H,H), 0, 0, 0, 5, 3);
        vec(1, 4'b0000, 4'b0001, 0, 32'h0000_5555, cc(P,P,B,B,P), 1, 32'h0000_4444, 1, 6, 3);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 6, 4);
        // equal index: live address wins over pending
        vec(1, 4'b0011, 4'b0010, 1, 32'h0000_AAAA, cc(P,P,B,H,H), 0, 0, 0, 6, 4);
        vec(1, 4'b0000, 4'b0010, 1, 32'h0000_BBBB, cc(P,P,P,B,P), 1, 32'h0000_BBBB, 1, 7, 4);
        // flush at 3 overrides a younger stall at 2
        vec(1, 4'b0100, 4'b1000, 3, 32'h0000_C000, cc(P,B,B,B,P), 1, 32'h0000_C000, 0, 7, 5);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 7, 6);
        // reset while a flush is pending
        vec(1, 4'b1000, 4'b0100, 2, 32'h0000_D000, cc(B,H,H,H,H), 0, 0, 0, 7, 6);
        vec(0, 4'b0000, 4'b0000, 0, 0, cc(B,B,B,B,B), 0, 0, 1, 8, 6);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 0, 0);
        // stall counter saturation
        for (int n = 0; n < 20; n++)
            vec(1, 4'b0001, 4'b0000, 0, 0, cc(P,P,P,B,H), 0, 0, 0, (n > 15) ? 4'd15 : 4'(n), 0);
        vec(1, 4'b0000, 4'b0000, 0, 0, cc(P,P,P,P,P), 0, 0, 0, 15, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain %0d expectations left want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_hazard.md
# ctrl_pipe_hazard

Parametrised pipeline hazard controller for the RISC-V core. It is the successor to the fixed five-register stall controller. It resolves per-stage stall requests and per-stage flush (redirect) requests into a per-pipeline-register `Pass`/`Hold`/`Bubb` control code. A flush that cannot be applied because of an older stall is held internally until it can be applied, and the block keeps saturating stall and flush event counters. It sits beside the datapath and drives the PC register and every inter-stage pipeline register.

## Interface
Parameters:
- `NSTAGE`, default 4: number of stages that can request a stall or flush. Stage 0 is IF. Controls `NSTAGE+1` pipeline registers; register 0 is the PC, and register s+1 is written by stage s.
- `AW`, default 32: redirect address width.
- `CNT_W`, default 32: width of the event counters.

Ports:
- `clk`  in  1  clock; everything updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `stall_req`  in  NSTAGE  bit s set: stage s must hold this cycle.
- `flush_req`  in  NSTAGE  bit k set: stage k resolved a redirect, so every instruction younger than stage k is wrong.
- `flush_addr`  in  NSTAGE*AW  redirect target for stage k, in slice `[k*AW +: AW]`.
- `stall_ctrl`  out  2*(NSTAGE+1)  control code for register i, in slice `[2i +: 2]`. Codes are the `Pass`/`Hold`/`Bubb` macros from config.v.
- `redirect_valid`  out  1  PC register must load `redirect_addr` this cycle.
- `redirect_addr`  out  AW  redirect target.
- `flush_pending`  out  1  a deferred flush is held.
- `stall_cycles`  out  CNT_W  saturating count of cycles with any `Hold` code.
- `flush_count`  out  CNT_W  saturating count of applied flushes.

## Operation
- **Stall resolution.** Let j be the highest index with `stall_req[j]` set.
  - Registers 0..j get `Hold`.
  - Register j+1 gets `Bubb`.
  - Registers above j+1 get `Pass`.
  - With no stall, every register gets `Pass`.
- **Flush candidate.**
  - Among the live `flush_req` bits, the highest index k wins.
  - A pending flush with index p competes as if it were live.
  - When the live and pending indices are equal, the live request and its address win.
  - A live request with index below p is ignored, because that stage is younger than the pending flush and will be killed.
- **Applying the flush.** The candidate k is applied only if no `stall_req` bit at index ≥ k is set. When applied:
  - Registers 1..k get `Bubb`.
  - Register 0 gets `Pass`, with `redirect_valid`=1 and `redirect_addr` = the candidate's address.
  - Registers above k get `Pass`.
  - Any stall requests at indices below k are overridden.
- **Deferring the flush.** If the candidate is blocked by a stall at index ≥ k:
  - Outputs follow the stall-resolution pattern and `redirect_valid`=0.
  - At the clock edge the block latches {valid, k, address} into its pending register.
- **Pending register update, at each edge:**
  - Cleared when a flush is applied.
  - Loaded when a candidate is deferred.
  - Otherwise unchanged.
  - `flush_pending` is the valid bit of the pending register.
- **Counters.**
  - `stall_cycles` increments when any field of `stall_ctrl` is `Hold`.
  - `flush_count` increments when a flush is applied.
  - Both saturate at all-ones and never wrap.
- **Reset.** While `rst_n`=0 at an edge:
  - The pending register and both counters clear.
  - Combinationally during reset, every `stall_ctrl` field is `Bubb`, `redirect_valid`=0 and `redirect_addr`=0.
  - Reset overrides all requests.

## Timing
- `stall_ctrl`, `redirect_valid` and `redirect_addr` are combinational from the inputs, the pending register and `rst_n`. They have zero latency, so the datapath acts on them at the same edge.
- `flush_pending` and the counters are registered and show the effect of cycle N at cycle N+1.
- A deferred flush is applied in the first cycle in which no stall is requested at index ≥ k. The requester may deassert `flush_req` after the deferral.
- A pending flush and a reset in the same cycle: reset wins and the flush is lost.
- A flush is applied in the same cycle as the live request when it is not blocked. There are no extra bubbles beyond registers 1..k.

## Test plan
- **No requests.** `NSTAGE`=4 with all requests 0 → all five fields are `Pass`, `redirect_valid`=0, and both counters hold.
- **Stall only.** `stall_req`=4'b0100 → fields 0–2 `Hold`, field 3 `Bubb`, field 4 `Pass`. `stall_cycles` goes from 0 to 1 at the next cycle.
- **Direct flush.** `flush_req`=4'b0100 with address 0x0000_1000 and no stall → fields 1–2 `Bubb`, `redirect_valid`=1, `redirect_addr`=0x1000, and `flush_count` becomes 1.
- **Deferred flush.** `flush_req[2]` with address 0x2000 and `stall_req[3]` set for 3 cycles, then the flush request drops → `redirect_valid`=0 and `flush_pending`=1 for those cycles. In the cycle the stall releases: `redirect_valid`=1, `redirect_addr`=0x2000, fields 1–2 `Bubb`. `flush_pending` returns to 0 at the next cycle.
- **Competing flushes.** Pending flush at k=1 with a live `flush_req[3]` at 0x3000 → the k=3 flush is applied (fields 1–3 `Bubb`, `redirect_addr`=0x3000). A live `flush_req[0]` alongside a pending k=2 is ignored.
- **Reset and saturation.** `rst_n`=0 during a pending flush → all fields `Bubb`, `redirect_valid`=0, and `flush_pending` and both counters read 0 at the next cycle. With `CNT_W`=4, 20 consecutive stall cycles → `stall_cycles` reads 15.
